// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the axi4_lite_slave_regs register bank.
// Master drives requests; slave drives readies and responses.
interface axi4_lite_slave_regs_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank with byte strobes and a flat register export.
// Define AXIL_PRIV_CHECK_EN to reject unprivileged (prot[0]=0) accesses.
module axi4_lite_slave_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          NUM_REGS  = 8
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   axi4_lite_slave_regs_if.slave     bus,
   output logic [32*NUM_REGS-1:0]    regs_out
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic [NUM_REGS-1:0][31:0] regs;

   logic        live;
   logic        aw_got;
   logic        w_got;
   logic        aw_ok_q;
   logic [9:0]  aw_idx_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic [1:0]  bresp;
   logic        bvalid;
   logic [1:0]  rresp;
   logic        rvalid;
   logic [31:0] rdata;

   logic        awready;
   logic        wready;
   logic        arready;
   logic        aw_hs;
   logic        w_hs;
   logic        ar_hs;
   logic        aw_ok_now;
   logic        ar_ok_now;
   logic        wr_ok;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [31:0] rd_sel;

   function automatic logic decode(input logic [29:0] a);
      return (a[29:10] == BASE_ADDR[31:12]) &&
             ({22'd0, a[9:0]} < 32'(NUM_REGS));
   endfunction

`ifdef AXIL_PRIV_CHECK_EN
   assign aw_ok_now = decode(bus.awaddr[31:2]) && bus.awprot[0];
   assign ar_ok_now = decode(bus.araddr[31:2]) && bus.arprot[0];
   logic unused_bits;
   assign unused_bits = ^{bus.awaddr[1:0], bus.araddr[1:0],
                          bus.awprot[2:1], bus.arprot[2:1]};
`else
   assign aw_ok_now = decode(bus.awaddr[31:2]);
   assign ar_ok_now = decode(bus.araddr[31:2]);
   logic unused_bits;
   assign unused_bits = ^{bus.awaddr[1:0], bus.araddr[1:0],
                          bus.awprot, bus.arprot};
`endif

   // live holds the readies low for the whole reset and its release edge
   assign awready = live && (w_state == W_IDLE) && !aw_got;
   assign wready  = live && (w_state == W_IDLE) && !w_got;
   assign arready = live && (r_state == R_IDLE);

   assign aw_hs = bus.awvalid && awready;
   assign w_hs  = bus.wvalid && wready;
   assign ar_hs = bus.arvalid && arready;

   assign wr_ok   = aw_got ? aw_ok_q  : aw_ok_now;
   assign wr_idx  = aw_got ? aw_idx_q : bus.awaddr[11:2];
   assign wr_data = w_got  ? wdata_q  : bus.wdata;
   assign wr_strb = w_got  ? wstrb_q  : bus.wstrb;

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.araddr[11:2] == 10'(i)) rd_sel = regs[i];
      end
   end

   assign bus.awready = awready;
   assign bus.wready  = wready;
   assign bus.arready = arready;
   assign bus.bresp   = bresp;
   assign bus.bvalid  = bvalid;
   assign bus.rresp   = rresp;
   assign bus.rvalid  = rvalid;
   assign bus.rdata   = rdata;
   assign regs_out    = regs;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         live     <= 1'b0;
         w_state  <= W_IDLE;
         r_state  <= R_IDLE;
         regs     <= '0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         aw_ok_q  <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp    <= RESP_OKAY;
         bvalid   <= 1'b0;
         rresp    <= RESP_OKAY;
         rvalid   <= 1'b0;
         rdata    <= '0;
      end else begin
         live <= 1'b1;

         unique case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_got   <= 1'b1;
                  aw_ok_q  <= aw_ok_now;
                  aw_idx_q <= bus.awaddr[11:2];
               end
               if (w_hs) begin
                  w_got   <= 1'b1;
                  wdata_q <= bus.wdata;
                  wstrb_q <= bus.wstrb;
               end
               if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                  if (wr_ok) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == 10'(i)) begin
                           for (int k = 0; k < 4; k++) begin
                              if (wr_strb[k])
                                 regs[i][8*k +: 8] <= wr_data[8*k +: 8];
                           end
                        end
                     end
                  end
                  bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                  bvalid  <= 1'b1;
                  w_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid  <= 1'b0;
                  aw_got  <= 1'b0;
                  w_got   <= 1'b0;
                  w_state <= W_IDLE;
               end
            end
         endcase

         // regs is sampled before this edge's write lands: read sees old data
         unique case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata   <= ar_ok_now ? rd_sel : 32'd0;
                  rresp   <= ar_ok_now ? RESP_OKAY : RESP_SLVERR;
                  rvalid  <= 1'b1;
                  r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rvalid  <= 1'b0;
                  r_state <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized scoreboard bench for axi4_lite_slave_regs.
// Expected responses are queued at issue time and checked by a monitor.
module tb_axi4_lite_slave_regs;

   localparam int NR = 8;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [32*NR-1:0] regs_out;

   axi4_lite_slave_regs_if bus ();

   axi4_lite_slave_regs dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .bus      (bus),
      .regs_out (regs_out)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int passes = 0;

   logic [31:0]     mdl [NR];
   logic [1:0]      eb_resp [$];
   logic [32*NR-1:0] eb_regs [$];
   logic [31:0]     er_data [$];
   logic [1:0]      er_resp [$];

   int bp_pct = 0;
   bit hold_b = 0;
   bit hold_r = 0;

   function automatic void chk(input string name,
                               input logic [255:0] act,
                               input logic [255:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endfunction

   function automatic void fail(input string name);
      checks++;
      $display("FAIL %s: got timeout want response", name);
   endfunction

   function automatic bit m_hit(input logic [31:0] a, input logic [2:0] p);
      bit h;
      h = (a[31:12] == 20'h00003) && (int'(a[11:2]) < NR);
`ifdef AXIL_PRIV_CHECK_EN
      h = h && p[0];
`else
      if (p == 3'b111) h = h;
`endif
      return h;
   endfunction

   function automatic logic [32*NR-1:0] snap();
      logic [32*NR-1:0] s;
      for (int i = 0; i < NR; i++) s[32*i +: 32] = mdl[i];
      return s;
   endfunction

   function automatic void exp_write(input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] s, input logic [2:0] p);
      bit h;
      int idx;
      h = m_hit(a, p);
      if (h) begin
         idx = int'(a[11:2]);
         for (int k = 0; k < 4; k++)
            if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      end
      eb_resp.push_back(h ? 2'b00 : 2'b10);
      eb_regs.push_back(snap());
   endfunction

   function automatic void exp_read(input logic [31:0] a, input logic [2:0] p);
      bit h;
      h = m_hit(a, p);
      er_data.push_back(h ? mdl[int'(a[11:2])] : 32'd0);
      er_resp.push_back(h ? 2'b00 : 2'b10);
   endfunction

   task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p,
                              input int aw_dly, input int w_dly);
      bit aw_pend = 1;
      bit w_pend = 1;
      int t = 0;
      while ((aw_pend || w_pend) && t < 200) begin
         bus.awaddr  = a;
         bus.awprot  = p;
         bus.wdata   = d;
         bus.wstrb   = s;
         bus.awvalid = aw_pend && (t >= aw_dly);
         bus.wvalid  = w_pend && (t >= w_dly);
         @(negedge aclk);
         if (aw_pend && !w_pend)
            chk("w_captured_readies", {bus.awready, bus.wready}, 2'b10);
         if (!aw_pend && w_pend)
            chk("aw_captured_readies", {bus.awready, bus.wready}, 2'b01);
         if (bus.awvalid && bus.awready) aw_pend = 0;
         if (bus.wvalid && bus.wready) w_pend = 0;
         @(posedge aclk);
         #1;
         t++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (aw_pend || w_pend) fail("write_handshake");
      else chk("b_latency", bus.bvalid, 1'b1);
   endtask

   task automatic drive_read(input logic [31:0] a, input logic [2:0] p);
      bit pend = 1;
      int t = 0;
      while (pend && t < 200) begin
         bus.araddr  = a;
         bus.arprot  = p;
         bus.arvalid = 1'b1;
         @(negedge aclk);
         if (bus.arready) pend = 0;
         @(posedge aclk);
         #1;
         t++;
      end
      bus.arvalid = 1'b0;
      if (pend) fail("read_handshake");
      else chk("r_latency", bus.rvalid, 1'b1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((eb_resp.size() != 0 || er_data.size() != 0) && t < 300) begin
         @(posedge aclk);
         t++;
      end
      if (eb_resp.size() != 0 || er_data.size() != 0) begin
         fail("response_wait");
         eb_resp.delete();
         eb_regs.delete();
         er_data.delete();
         er_resp.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int aw_dly, input int w_dly);
      exp_write(a, d, s, 3'b001);
      drive_write(a, d, s, 3'b001, aw_dly, w_dly);
      wait_idle();
   endtask

   task automatic rd(input logic [31:0] a);
      exp_read(a, 3'b001);
      drive_read(a, 3'b001);
      wait_idle();
   endtask

   always @(posedge aclk) begin
      #1;
      bus.bready = !hold_b && (int'($urandom_range(99)) >= bp_pct);
      bus.rready = !hold_r && (int'($urandom_range(99)) >= bp_pct);
   end

   bit b_fire = 0;
   bit b_hold = 0;
   bit r_fire = 0;
   bit r_hold = 0;

   always @(negedge aclk) begin
      if (!aresetn) begin
         b_fire = 0;
         b_hold = 0;
         r_fire = 0;
         r_hold = 0;
      end else begin
         if (b_fire) chk("b_single_pulse", bus.bvalid, 1'b0);
         if (b_hold) chk("b_held", bus.bvalid, 1'b1);
         if (bus.bvalid) begin
            chk("b_readies_low", {bus.awready, bus.wready}, 2'b00);
            if (eb_resp.size() == 0) fail("b_unexpected");
            else begin
               chk("bresp", bus.bresp, eb_resp[0]);
               chk("regs_out", regs_out, eb_regs[0]);
               if (bus.bready) begin
                  void'(eb_resp.pop_front());
                  void'(eb_regs.pop_front());
               end
            end
         end
         b_fire = bus.bvalid && bus.bready;
         b_hold = bus.bvalid && !bus.bready;

         if (r_fire) chk("r_single_pulse", bus.rvalid, 1'b0);
         if (r_hold) chk("r_held", bus.rvalid, 1'b1);
         if (bus.rvalid) begin
            chk("r_arready_low", bus.arready, 1'b0);
            if (er_data.size() == 0) fail("r_unexpected");
            else begin
               chk("rdata", bus.rdata, er_data[0]);
               chk("rresp", bus.rresp, er_resp[0]);
               if (bus.rready) begin
                  void'(er_data.pop_front());
                  void'(er_resp.pop_front());
               end
            end
         end
         r_fire = bus.rvalid && bus.rready;
         r_hold = bus.rvalid && !bus.rready;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [2:0]  p;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.bready = 1'b0; bus.rready = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("reset_outputs",
          {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid},
          5'b00000);
      chk("reset_data", {bus.rdata, bus.bresp, bus.rresp}, 36'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      chk("readies_after_release",
          {bus.awready, bus.wready, bus.arready}, 3'b111);
      chk("regs_after_reset", regs_out, 256'd0);
      @(posedge aclk);
      #1;

      rd(32'h3004);
      wr(32'h3008, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("deadbeef_export", regs_out[95:64], 32'hDEADBEEF);
      rd(32'h3008);

      wr(32'h3000, 32'hAABBCCDD, 4'hF, 0, 0);
      wr(32'h3000, 32'h11223344, 4'b0101, 3, 0);
      chk("strobe_merge", regs_out[31:0], 32'hAA22CC44);
      wr(32'h3004, 32'h55667788, 4'b0000, 0, 2);

      wr(32'h3020, 32'hCAFEF00D, 4'hF, 0, 0);
      rd(32'h4000);
      rd(32'h301F);

      hold_b = 1;
      exp_write(32'h3010, 32'h0BADF00D, 4'hF, 3'b001);
      drive_write(32'h3010, 32'h0BADF00D, 4'hF, 3'b001, 1, 0);
      repeat (5) @(posedge aclk);
      hold_b = 0;
      wait_idle();
      hold_r = 1;
      exp_read(32'h3010, 3'b001);
      drive_read(32'h3010, 3'b001);
      repeat (5) @(posedge aclk);
      hold_r = 0;
      wait_idle();

      exp_read(32'h300C, 3'b001);
      exp_write(32'h300C, 32'h12345678, 4'hF, 3'b001);
      fork
         drive_read(32'h300C, 3'b001);
         drive_write(32'h300C, 32'h12345678, 4'hF, 3'b001, 0, 0);
      join
      wait_idle();
      rd(32'h300C);

      bus.awaddr = 32'h3004;
      bus.awprot = 3'b001;
      bus.awvalid = 1'b1;
      @(negedge aclk);
      @(posedge aclk);
      #1 bus.awvalid = 1'b0;
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("midwrite_reset_regs", regs_out, 256'd0);
      chk("midwrite_reset_bvalid", bus.bvalid, 1'b0);
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      @(posedge aclk);
      #1 aresetn = 1'b1;
      wr(32'h3000, 32'h600DCAFE, 4'hF, 0, 0);

      exp_write(32'h3008, 32'hFFFF0000, 4'hF, 3'b000);
      drive_write(32'h3008, 32'hFFFF0000, 4'hF, 3'b000, 0, 0);
      wait_idle();
      exp_read(32'h3000, 3'b010);
      drive_read(32'h3000, 3'b010);
      wait_idle();

      bp_pct = 30;
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(9))
            0: a = $urandom;
            1: a = 32'h4000 + 32'($urandom_range(255));
            default: a = 32'h3000 + 32'(4 * $urandom_range(9))
                         + 32'($urandom_range(3));
         endcase
         d = $urandom;
         s = 4'($urandom_range(15));
         p = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b001;
         case ($urandom_range(4))
            0, 1: begin
               exp_write(a, d, s, p);
               drive_write(a, d, s, p, $urandom_range(3), $urandom_range(3));
            end
            2, 3: begin
               exp_read(a, p);
               drive_read(a, p);
            end
            default: begin
               exp_read(a, p);
               exp_write(a, d, s, p);
               fork
                  drive_read(a, p);
                  drive_write(a, d, s, p, 0, 0);
               join
            end
         endcase
         wait_idle();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite slave register bank that sits directly downstream of the 2x2 AXI4-Lite crossbar, on one slave port (default window 0x0000_3000-0x0000_3FFF).
- Provides NUM_REGS 32-bit read/write registers with byte strobes, full valid/ready handshakes on all five channels, and OKAY/SLVERR responses.
- Register contents are also exported as a flat bus for local hardware use.

Parameters:
- BASE_ADDR, 32'h0000_3000: base of the 4 KiB window; only bits [31:12] are compared.
- NUM_REGS, 8: number of 32-bit registers, 1-64; register i is at BASE_ADDR + 4*i.

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- awaddr  in  32  write address
- awprot  in  3  write protection
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  32  read address
- arprot  in  3  read protection
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- regs_out  out  32*NUM_REGS  all registers; register i is at bits [32*i+31:32*i]

Behaviour:
- Reset (aresetn=0 at clock edge):
  - All registers = 0; bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - awready=wready=arready=0 during reset; they rise on the first cycle after release.
  - Any in-flight transaction is dropped.
- Address decode:
  - hit = (addr[31:12]==BASE_ADDR[31:12]) && (addr[11:2] < NUM_REGS).
  - addr[1:0] is ignored.
  - Miss -> SLVERR, no register change, rdata=0.
- Write FSM states: W_IDLE, W_RESP.
  - awready=1 in W_IDLE while AW is not yet captured; wready=1 in W_IDLE while W is not yet captured.
  - AW and W are accepted in either order or in the same cycle. Each is latched on its own handshake (valid&&ready).
  - On the edge where the second of the two handshakes completes:
    - Register write is performed: byte k is updated iff wstrb[k]=1.
    - bresp is set and bvalid goes 1; state becomes W_RESP.
  - W_RESP: bvalid held with bresp stable until bready=1. On that edge bvalid goes 0, both captured flags clear, and the state returns to W_IDLE. awready/wready rise the next cycle.
  - A write with wstrb=0 is legal: OKAY, no change.
  - Minimum write cadence: 2 cycles with bready tied high.
- Read FSM states: R_IDLE, R_DATA.
  - arready=1 only in R_IDLE.
  - On the AR handshake edge: rdata = selected register (or 0), rresp set, rvalid goes 1, state becomes R_DATA.
  - R_DATA: rdata/rresp/rvalid held until rready=1. Then rvalid goes 0 and the state returns to R_IDLE.
- Channel independence: read and write paths run concurrently.
  - If a read and a write to the same register complete on the same edge, the read returns the pre-write value.
  - regs_out shows the new value the cycle after the write edge.
- Protocol: outputs never depend combinationally on inputs. All ready and valid outputs are registers or decoded from state and flags.
- awprot/arprot are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: AXIL_PRIV_CHECK_EN.
- When defined:
  - A write whose awprot[0]=0 (unprivileged) returns SLVERR and does not modify registers.
  - A read whose arprot[0]=0 returns SLVERR with rdata=0.
  - Protection is checked in addition to the address decode; either failure gives SLVERR.
- When undefined: prot inputs are unused and all in-range accesses return OKAY.

Test Plan:
- Reset, then read 0x3004 with rready=1 -> rdata=0, rresp=00, rvalid high exactly 1 cycle; awready=wready=arready=1 after release.
- AW/W same cycle: awaddr=0x3008, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid next cycle with bresp=00; regs_out[95:64]=0xDEADBEEF; read 0x3008 returns 0xDEADBEEF.
- W 3 cycles before AW: wdata=0x11223344, wstrb=4'b0101 to 0x3000 holding 0xAABBCCDD -> awready stays 1 while wready=0 after W accepted; result 0xAA22CC44, bresp=00.
- Out of range: write 0x3020 (NUM_REGS=8) and read 0x4000 -> bresp=10 and rresp=10, rdata=0, no register changes.
- Backpressure: bready=0 for 5 cycles after write completes -> bvalid and bresp stable, awready=wready=0 throughout. Same with rready=0 on the read side: rdata stable.
- Reset mid-write: AW accepted, aresetn=0 before W -> all registers 0 and bvalid=0 after reset. A fresh write to 0x3000 then completes normally. With AXIL_PRIV_CHECK_EN: write with awprot=3'b000 -> bresp=10, register unchanged.
